// File: rtl/core_branch_predict_unit.sv
// core_branch_predict_unit: branch compare/target resolve plus direct-mapped BTB predictor with 2-bit counters.
`ifndef BR_OP_WIDTH
`define BR_OP_WIDTH 3
`define BR_EQ  3'd0
`define BR_NE  3'd1
`define BR_LT  3'd2
`define BR_GE  3'd3
`define BR_LTU 3'd4
`define BR_GEU 3'd5
`endif

module core_branch_predict_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_WIDTH   = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH-1:0]   fetch_pc_i,
    output logic                    pred_taken_o,
    output logic [DATA_WIDTH-1:0]   pred_target_o,
    input  logic                    resolve_valid_i,
    input  logic [`BR_OP_WIDTH-1:0] BR_op_i,
    input  logic                    jump_i,
    input  logic                    jalr_i,
    input  logic [DATA_WIDTH-1:0]   pc_i,
    input  logic [DATA_WIDTH-1:0]   imm_val_i,
    input  logic [DATA_WIDTH-1:0]   regfile_rs1_i,
    input  logic [DATA_WIDTH-1:0]   regfile_rs2_i,
    input  logic                    pred_taken_i,
    input  logic [DATA_WIDTH-1:0]   pred_target_i,
    output logic                    branch_o,
    output logic [DATA_WIDTH-1:0]   brj_pc_o,
    output logic                    misaligned_o,
    output logic                    mispredict_o,
    output logic [DATA_WIDTH-1:0]   redirect_pc_o,
    output logic [CNT_WIDTH-1:0]    br_cnt_o,
    output logic [CNT_WIDTH-1:0]    mp_cnt_o
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);

    logic [BTB_ENTRIES-1:0] valid_q, jmp_q;
    logic [TAG_WIDTH-1:0]   tag_q [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]  target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];
    logic [CNT_WIDTH-1:0]   br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
    logic [1:0]             ctr_d;

    logic [IDX_W-1:0]      fidx, widx;
    logic [TAG_WIDTH-1:0]  ftag, wtag;
    logic                  fhit, whit;
    logic [DATA_WIDTH-1:0] sum, tgt;
    logic                  is_br, cmp, taken, train, wr_en;
    logic                  unused_ok;

    assign fidx          = fetch_pc_i[IDX_W+1:2];
    assign ftag          = fetch_pc_i[TAG_WIDTH+IDX_W+1:IDX_W+2];
    assign fhit          = valid_q[fidx] & (tag_q[fidx] == ftag);
    assign pred_taken_o  = fhit & (jmp_q[fidx] | ctr_q[fidx][1]);
    assign pred_target_o = pred_taken_o ? target_q[fidx] : '0;

    assign sum   = (jalr_i ? regfile_rs1_i : pc_i) + imm_val_i;
    assign tgt   = {sum[DATA_WIDTH-1:1], 1'b0};
    assign is_br = BR_op_i <= `BR_GEU;
    assign cmp   = (BR_op_i == `BR_EQ)  ? (regfile_rs1_i == regfile_rs2_i) :
                   (BR_op_i == `BR_NE)  ? (regfile_rs1_i != regfile_rs2_i) :
                   (BR_op_i == `BR_LT)  ? ($signed(regfile_rs1_i) <  $signed(regfile_rs2_i)) :
                   (BR_op_i == `BR_GE)  ? ($signed(regfile_rs1_i) >= $signed(regfile_rs2_i)) :
                   (BR_op_i == `BR_LTU) ? (regfile_rs1_i <  regfile_rs2_i) :
                   (BR_op_i == `BR_GEU) ? (regfile_rs1_i >= regfile_rs2_i) : 1'b0;
    assign taken = resolve_valid_i & (jump_i | (is_br & cmp));

    assign branch_o      = taken;
    assign brj_pc_o      = resolve_valid_i ? tgt : '0;
    assign misaligned_o  = taken & tgt[1];
    assign mispredict_o  = resolve_valid_i & ((taken != pred_taken_i) | (taken & (pred_target_i != tgt)));
    assign redirect_pc_o = !resolve_valid_i ? '0 : taken ? tgt : pc_i + DATA_WIDTH'(4);

    // Training is looked up by the resolving PC, independent of the fetch-side read.
    assign widx  = pc_i[IDX_W+1:2];
    assign wtag  = pc_i[TAG_WIDTH+IDX_W+1:IDX_W+2];
    assign whit  = valid_q[widx] & (tag_q[widx] == wtag);
    assign train = resolve_valid_i & ~misaligned_o & (is_br | jump_i);
    assign wr_en = train & (whit | taken);

    always_comb begin
        ctr_d    = jump_i ? 2'd3 :
                   !whit  ? 2'd2 :
                   taken  ? ((ctr_q[widx] == 2'd3) ? 2'd3 : ctr_q[widx] + 2'd1) :
                            ((ctr_q[widx] == 2'd0) ? 2'd0 : ctr_q[widx] - 2'd1);
        br_cnt_d = br_cnt_q + CNT_WIDTH'(train & ~&br_cnt_q);
        mp_cnt_d = mp_cnt_q + CNT_WIDTH'(mispredict_o & ~&mp_cnt_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                jmp_q[i]    <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[widx] <= 1'b1;
                jmp_q[widx]   <= jump_i;
                tag_q[widx]   <= wtag;
                ctr_q[widx]   <= ctr_d;
                if (taken) target_q[widx] <= tgt;
            end
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign br_cnt_o  = br_cnt_q;
    assign mp_cnt_o  = mp_cnt_q;
    assign unused_ok = ^{fetch_pc_i, pc_i, sum};
endmodule

// File: tb/tb_core_branch_predict_unit.sv
// tb_core_branch_predict_unit: scoreboard bench comparing the predictor/resolver against a behavioural model.
`ifndef BR_OP_WIDTH
`define BR_OP_WIDTH 3
`define BR_EQ  3'd0
`define BR_NE  3'd1
`define BR_LT  3'd2
`define BR_GE  3'd3
`define BR_LTU 3'd4
`define BR_GEU 3'd5
`endif

module tb_core_branch_predict_unit;
    localparam int N  = 16;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fpc, pc, imm, rs1, rs2, ptg;
    logic [2:0]  op;
    logic        rv, jmp, jalr, pti;
    logic        pred_taken, branch, misaligned, mispredict;
    logic [31:0] pred_target, brj_pc, redirect_pc;
    logic [CW-1:0] br_cnt, mp_cnt;

    always #5 clk = ~clk;

    core_branch_predict_unit #(.DATA_WIDTH(32), .BTB_ENTRIES(N), .TAG_WIDTH(8), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .fetch_pc_i(fpc), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
        .resolve_valid_i(rv), .BR_op_i(op), .jump_i(jmp), .jalr_i(jalr), .pc_i(pc), .imm_val_i(imm),
        .regfile_rs1_i(rs1), .regfile_rs2_i(rs2), .pred_taken_i(pti), .pred_target_i(ptg),
        .branch_o(branch), .brj_pc_o(brj_pc), .misaligned_o(misaligned), .mispredict_o(mispredict),
        .redirect_pc_o(redirect_pc), .br_cnt_o(br_cnt), .mp_cnt_o(mp_cnt)
    );

    typedef struct packed {
        logic pt; logic [31:0] ptgt; logic br; logic [31:0] bpc; logic mis; logic mp;
        logic [31:0] rpc; logic [CW-1:0] bc; logic [CW-1:0] mc;
    } exp_t;
    exp_t sbq[$];

    int n_tests = 0, n_fail = 0;
    logic          m_v [N];
    logic [7:0]    m_tag [N];
    logic [31:0]   m_tgt [N];
    logic [1:0]    m_ctr [N];
    logic          m_j [N];
    logic [CW-1:0] m_bc, m_mc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 2'b01; m_j[i] = 0;
        end
        m_bc = 0; m_mc = 0;
    endtask

    task automatic idle(input logic [31:0] f);
        rv = 0; op = 3'd7; jmp = 0; jalr = 0; pc = 0; imm = 0; rs1 = 0; rs2 = 0; pti = 0; ptg = 0; fpc = f; rst = 0;
    endtask

    task automatic resolve(input logic [2:0] o, input logic j, input logic jr, input logic [31:0] p,
                           input logic [31:0] im, input logic [31:0] a, input logic [31:0] b,
                           input logic pt, input logic [31:0] pg);
        rv = 1; op = o; jmp = j; jalr = jr; pc = p; imm = im; rs1 = a; rs2 = b; pti = pt; ptg = pg;
    endtask

    // Drive happens before the call; compare mid-cycle, then advance the model on the edge.
    task automatic step();
        exp_t e, x;
        logic [31:0] s;
        logic cmp, isb, tk, trn, hit;
        int fi, wi;
        fi = int'(fpc[5:2]);
        wi = int'(pc[5:2]);
        e = '0;
        e.pt = m_v[fi] && m_tag[fi] == fpc[13:6] && (m_j[fi] || m_ctr[fi][1]);
        e.ptgt = e.pt ? m_tgt[fi] : 32'h0;
        case (op)
            `BR_EQ:  cmp = rs1 == rs2;
            `BR_NE:  cmp = rs1 != rs2;
            `BR_LT:  cmp = $signed(rs1) < $signed(rs2);
            `BR_GE:  cmp = $signed(rs1) >= $signed(rs2);
            `BR_LTU: cmp = rs1 < rs2;
            `BR_GEU: cmp = rs1 >= rs2;
            default: cmp = 0;
        endcase
        isb = op <= 3'd5;
        s = (jalr ? rs1 : pc) + imm;
        s[0] = 1'b0;
        tk = rv && (jmp || (isb && cmp));
        if (rv) begin
            e.br  = tk;
            e.bpc = s;
            e.mis = tk && s[1];
            e.mp  = (tk != pti) || (tk && ptg != s);
            e.rpc = tk ? s : pc + 32'd4;
        end
        e.bc = m_bc;
        e.mc = m_mc;
        trn = rv && !e.mis && (isb || jmp);
        sbq.push_back(e);
        #4;
        x = sbq.pop_front();
        check("pred_taken", pred_taken, x.pt);
        check("pred_target", pred_target, x.ptgt);
        check("branch", branch, x.br);
        check("brj_pc", brj_pc, x.bpc);
        check("misaligned", misaligned, x.mis);
        check("mispredict", mispredict, x.mp);
        check("redirect_pc", redirect_pc, x.rpc);
        check("br_cnt", br_cnt, x.bc);
        check("mp_cnt", mp_cnt, x.mc);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            hit = m_v[wi] && m_tag[wi] == pc[13:6];
            if (trn && hit) begin
                if (jmp) m_ctr[wi] = 3;
                else if (tk) m_ctr[wi] = (m_ctr[wi] == 3) ? 2'd3 : m_ctr[wi] + 2'd1;
                else m_ctr[wi] = (m_ctr[wi] == 0) ? 2'd0 : m_ctr[wi] - 2'd1;
                if (tk) m_tgt[wi] = s;
                m_j[wi] = jmp;
            end else if (trn && tk) begin
                m_v[wi] = 1; m_tag[wi] = pc[13:6]; m_tgt[wi] = s; m_ctr[wi] = jmp ? 2'd3 : 2'd2; m_j[wi] = jmp;
            end
            if (trn && m_bc != '1) m_bc++;
            if (e.mp && m_mc != '1) m_mc++;
        end
        #1;
    endtask

    initial begin
        idle(32'h100);
        rst = 1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        idle(32'h100); step();
        // BEQ taken, first sighting: mispredicts and allocates.
        resolve(`BR_EQ, 0, 0, 32'h100, 32'h40, 5, 5, 0, 0); step();
        idle(32'h100); #1;
        check("beq_pred_taken", pred_taken, 1);
        check("beq_pred_target", pred_target, 32'h140);
        check("beq_br_cnt", br_cnt, 1);
        check("beq_mp_cnt", mp_cnt, 1);
        for (int k = 0; k < 3; k++) begin
            resolve(`BR_EQ, 0, 0, 32'h100, 32'h40, 1, 2, k == 0, k == 0 ? 32'h140 : 0); step();
        end
        idle(32'h100); #1;
        check("nt_pred_taken", pred_taken, 0);
        resolve(`BR_EQ, 0, 0, 32'h100, 32'h40, 1, 2, 0, 0); #1;
        check("nt_redirect", redirect_pc, 32'h104);
        step();
        resolve(`BR_LT,  0, 0, 32'h200, 32'h8, 32'hFFFF_FFFF, 1, 0, 0); step();
        resolve(`BR_LTU, 0, 0, 32'h204, 32'h8, 32'hFFFF_FFFF, 1, 0, 0); step();
        resolve(3'd7, 1, 1, 32'h300, 0, 32'h8000_0003, 0, 0, 0); #1;
        check("jalr_tgt", brj_pc, 32'h8000_0002);
        check("jalr_misaligned", misaligned, 1);
        step();
        idle(32'h300); step();
        // Aliasing: 0x100 and 0x140 share an index with different tags.
        resolve(3'd7, 1, 0, 32'h100, 32'h20, 0, 0, 0, 0); step();
        resolve(`BR_GE, 0, 0, 32'h140, 32'h10, 3, 3, 0, 0); step();
        idle(32'h100); step();
        idle(32'h140); step();
        // Reset overrides a simultaneous training write.
        resolve(`BR_EQ, 0, 0, 32'h180, 32'h40, 0, 0, 0, 0); rst = 1; step();
        idle(32'h180); step();
        for (int k = 0; k < 300; k++) begin
            resolve(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    32'h100 + 32'($urandom_range(0, 7)) * 32'h40 + 32'($urandom_range(0, 3)) * 4,
                    32'($urandom_range(0, 63)) * 2, 32'($urandom_range(0, 3)) - 1, 32'($urandom_range(0, 3)) - 1,
                    1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7)) * 4);
            rv = $urandom_range(0, 4) != 0;
            fpc = 32'h100 + 32'($urandom_range(0, 7)) * 32'h40 + 32'($urandom_range(0, 3)) * 4;
            rst = $urandom_range(0, 60) == 0;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
